// File: rtl/ex_alu_pipe_if.sv
// Request/result handshake bundle for the execute-stage ALU pipe.
// master drives requests and consumes results; slave is the ALU side.
interface ex_alu_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_data;
    logic            out_wen;

    modport master (
        output in_valid, in_op, in_rd, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_rd, out_data, out_wen
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_a, in_b, out_ready,
        output in_ready, out_valid, out_rd, out_data, out_wen
    );
endinterface

// File: rtl/ex_alu_pipe.sv
// Execute-stage integer ALU with a registered, ready/valid result slot.
// Define EX_ALU_ITER_SHIFT_EN to replace the barrel shifter with a 1-bit-per-clock shifter.
module ex_alu_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          rst,
    ex_alu_pipe_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SRA   = 4'd8,
        OP_SRL   = 4'd9,
        OP_PASSB = 4'd10
    } op_t;

    state_t state_q, state_d;
    logic   accept;
    logic   go_busy;
    logic   busy_done;

    function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_SLL:   return a << sh;
            OP_SLT:   return XLEN'($signed(a) < $signed(b));
            OP_SLTU:  return XLEN'(a < b);
            OP_SRA:   return XLEN'($signed(a) >>> sh);
            OP_SRL:   return a >> sh;
            OP_PASSB: return b;
            default:  return '0;
        endcase
    endfunction

`ifdef EX_ALU_ITER_SHIFT_EN
    logic [SHW-1:0] cnt_q, cnt_nxt, shamt_q;
    logic [3:0]     op_q;

    assign go_busy   = (bus.in_op == OP_SLL || bus.in_op == OP_SRA || bus.in_op == OP_SRL)
                       && (bus.in_b[SHW-1:0] != '0);
    assign cnt_nxt   = cnt_q + SHW'(1);
    assign busy_done = (cnt_nxt == shamt_q);
`else
    assign go_busy   = 1'b0;
    assign busy_done = 1'b1;
`endif

    // in_ready is forced low while reset is held, even though state already reads IDLE.
    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        bus.in_ready = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready = 1'b1;
            DONE:    bus.in_ready = bus.out_ready;
            default: bus.in_ready = 1'b0;
        endcase
        if (rst) bus.in_ready = 1'b0;
    end

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = go_busy ? BUSY : DONE;
            BUSY: if (busy_done) state_d = DONE;
            DONE: begin
                if (accept)             state_d = go_busy ? BUSY : DONE;
                else if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Result slot; in iterative mode out_data doubles as the shift working register while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_rd   <= '0;
            bus.out_data <= '0;
            bus.out_wen  <= 1'b0;
`ifdef EX_ALU_ITER_SHIFT_EN
            cnt_q        <= '0;
            shamt_q      <= '0;
            op_q         <= '0;
`endif
        end else if (accept) begin
            bus.out_rd   <= bus.in_rd;
            bus.out_wen  <= (bus.in_op <= OP_PASSB) && (bus.in_rd != 5'd0);
            bus.out_data <= go_busy ? bus.in_a : alu_calc(bus.in_op, bus.in_a, bus.in_b);
`ifdef EX_ALU_ITER_SHIFT_EN
            cnt_q        <= '0;
            shamt_q      <= bus.in_b[SHW-1:0];
            op_q         <= bus.in_op;
`endif
        end
`ifdef EX_ALU_ITER_SHIFT_EN
        else if (state_q == BUSY) begin
            cnt_q <= cnt_nxt;
            case (op_q)
                OP_SLL:  bus.out_data <= {bus.out_data[XLEN-2:0], 1'b0};
                OP_SRA:  bus.out_data <= {bus.out_data[XLEN-1], bus.out_data[XLEN-1:1]};
                default: bus.out_data <= {1'b0, bus.out_data[XLEN-1:1]};
            endcase
        end
`endif
    end

endmodule
